instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the core's immediate/field decode path. Packs opcode class, register indices, funct fields and a 32-bit signed immediate into one RV32I instruction word.
- Used by the self-test instruction ROM builder and the bench stimulus generator to produce instruction memory contents in hardware.
- Two-stage valid/ready pipeline with backpressure, an emitted-instruction counter and an error flag.

Parameters:
CNT_W, 16, width of emitted-instruction counter
NOP_WORD, 32'h0000_0013, word emitted for an illegal format (addi x0,x0,0)

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
in_valid  input  1  input fields valid
in_ready  output  1  encoder can accept fields this cycle
fmt  input  4  0 R, 1 I-ALU, 2 LOAD, 3 S, 4 B, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR, 9-15 illegal
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2
funct3  input  3  funct3 field
funct7  input  7  funct7 field (R; I-ALU shifts)
imm  input  32  signed immediate value as produced by decode (byte offset for B/J; full upper value for U)
out_valid  output  1  instr valid
out_ready  input  1  consumer accepts instr
instr  output  32  encoded instruction
err  output  1  qualifies instr: illegal format or (optional) immediate range violation
count  output  CNT_W  number of instructions handed off

Behaviour:
- Reset, synchronous and active-high: out_valid=0, instr=0, err=0, count=0, both stage valids cleared. in_ready reads 1 on the first cycle after reset deasserts. A transfer in flight when reset is asserted is dropped.
- Stage 1 registers the raw fields when in_valid && in_ready. Stage 2 registers the assembled word and err.
- Latency: fields accepted at cycle N give out_valid at cycle N+2 when there is no stall. Throughput is one word per cycle.
- Stage 1 advances when !s2_valid || out_ready. in_ready = !s1_valid || s1_advance, so a full pipeline with out_ready=0 holds 2 entries and deasserts in_ready.
- Simultaneous accept and advance in the same cycle is legal and produces no bubble. Order is strictly preserved.
- While out_valid=1 and out_ready=0, instr and err hold stable.
- count increments by 1 on every out_valid && out_ready and wraps modulo 2^CNT_W.
- Packing per fmt (opcode is fixed per fmt):
  - R (0110011): {funct7, rs2, rs1, funct3, rd, op}
  - I-ALU (0010011): {imm[11:0], rs1, funct3, rd, op}. If funct3 is 001 or 101, bits [31:25] are replaced by funct7.
  - LOAD (0000011) and JALR (1100111): I layout.
  - S (0100011): {imm[11:5], rs2, rs1, funct3, imm[4:0], op}
  - B (1100011): {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}
  - LUI (0110111) and AUIPC (0010111): {imm[31:12], rd, op}
  - JAL (1101111): {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
- Fields a format does not use are ignored.
- Illegal fmt (9-15): instr=NOP_WORD, err=1.
- Out-of-range immediates are always truncated to the field bits. Truncation affects err only when the optional check is compiled in.

Optional Feature:
- Macro: IMM_RANGE_CHECK_EN.
- With the macro defined, err is also set when:
  - I-ALU, LOAD, S or JALR: imm is outside [-2048, 2047]
  - B: imm is outside [-4096, 4094] or imm[0]=1
  - JAL: imm is outside [-2^20, 2^20-2] or imm[0]=1
  - LUI or AUIPC: imm[11:0] != 0
  - The word is still emitted, using the truncated bits.
- Without the macro, err=1 only for an illegal fmt, and the range-check logic is absent.

Test Plan:
- fmt=1, rd=5, rs1=0, funct3=0, imm=-1 -> instr=0xFFF00293, err=0, out_valid exactly 2 cycles after accept.
- fmt=4, rs1=1, rs2=2, funct3=0, imm=8 -> 0x00208463. fmt=7, rd=1, imm=0x800 -> 0x001000EF. fmt=5, rd=10, imm=0x12345000 -> 0x12345537.
- Hold out_ready=0 and offer 3 back-to-back inputs -> in_ready=0 after 2 accepts. Release out_ready -> all 3 words emerge in order, one per cycle, and count=3.
- fmt=12 -> instr=0x00000013, err=1. With IMM_RANGE_CHECK_EN, fmt=3 and imm=2048 -> err=1 and instr[31:25]=7'b1000000; without the macro, err=0.
- Assert reset with both stages full -> next cycle out_valid=0, count=0, in_ready=1, and no stale word is emitted afterwards.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Field/instruction bus for instr_encoder: input fields with valid/ready on one
// side, the encoded word with valid/ready plus err/count on the other.
interface instr_encoder_if #(
  parameter int CNT_W = 16
);
  // Valid/ready: a transfer happens on a rising clk edge where valid && ready are
  // both high. A producer holding valid keeps its payload stable until that edge;
  // ready may depend combinationally on the far side's ready, never on valid.
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       fmt;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [31:0]      imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      instr;
  logic             err;
  logic [CNT_W-1:0] count;

  modport slave (
    input  in_valid, fmt, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, instr, err, count
  );

  modport master (
    output in_valid, fmt, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, instr, err, count
  );
endinterface

// File: rtl/instr_encoder.sv
// Two-stage RV32I instruction encoder with backpressure and a hand-off counter.
// Optional immediate range checking is enabled with the IMM_RANGE_CHECK_EN macro.
module instr_encoder #(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               reset,
  instr_encoder_if.slave     bus
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  logic             r_s1_valid;
  logic [3:0]       r_fmt;
  logic [4:0]       r_rd;
  logic [4:0]       r_rs1;
  logic [4:0]       r_rs2;
  logic [2:0]       r_f3;
  logic [6:0]       r_f7;
  logic [31:0]      r_imm;
  logic             r_s2_valid;
  logic [31:0]      r_instr;
  logic             r_err;
  logic [CNT_W-1:0] r_count;

  logic        w_s1_adv;
  logic        w_in_ready;
  logic        w_accept;
  logic [31:0] w_word;
  logic        w_fmt_err;
  logic        w_range_err;
  logic        w_err;

  assign w_s1_adv   = !r_s2_valid || bus.out_ready;
  assign w_in_ready = !r_s1_valid || w_s1_adv;
  assign w_accept   = bus.in_valid && w_in_ready;

  always_comb begin
    w_word    = NOP_WORD;
    w_fmt_err = 1'b0;
    case (r_fmt)
      4'd0: w_word = {r_f7, r_rs2, r_rs1, r_f3, r_rd, OP_R};
      4'd1: begin
        w_word = {r_imm[11:0], r_rs1, r_f3, r_rd, OP_IALU};
        // Shift-immediate forms carry funct7 in the upper immediate bits.
        if (r_f3 == 3'b001 || r_f3 == 3'b101) w_word[31:25] = r_f7;
      end
      4'd2: w_word = {r_imm[11:0], r_rs1, r_f3, r_rd, OP_LOAD};
      4'd3: w_word = {r_imm[11:5], r_rs2, r_rs1, r_f3, r_imm[4:0], OP_S};
      4'd4: w_word = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_f3,
                      r_imm[4:1], r_imm[11], OP_B};
      4'd5: w_word = {r_imm[31:12], r_rd, OP_LUI};
      4'd6: w_word = {r_imm[31:12], r_rd, OP_AUIPC};
      4'd7: w_word = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, OP_JAL};
      4'd8: w_word = {r_imm[11:0], r_rs1, r_f3, r_rd, OP_JALR};
      default: w_fmt_err = 1'b1;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic signed [31:0] w_imm_s;
  assign w_imm_s = $signed(r_imm);

  always_comb begin
    w_range_err = 1'b0;
    case (r_fmt)
      4'd1, 4'd2, 4'd3, 4'd8:
        w_range_err = (w_imm_s < -32'sd2048) || (w_imm_s > 32'sd2047);
      4'd4:
        w_range_err = (w_imm_s < -32'sd4096) || (w_imm_s > 32'sd4094) || r_imm[0];
      4'd5, 4'd6:
        w_range_err = (r_imm[11:0] != 12'd0);
      4'd7:
        w_range_err = (w_imm_s < -32'sd1048576) || (w_imm_s > 32'sd1048574) || r_imm[0];
      default: w_range_err = 1'b0;
    endcase
  end
`else
  assign w_range_err = 1'b0;
`endif

  assign w_err = w_fmt_err || w_range_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_fmt      <= 4'd0;
      r_rd       <= 5'd0;
      r_rs1      <= 5'd0;
      r_rs2      <= 5'd0;
      r_f3       <= 3'd0;
      r_f7       <= 7'd0;
      r_imm      <= 32'd0;
      r_s2_valid <= 1'b0;
      r_instr    <= 32'd0;
      r_err      <= 1'b0;
      r_count    <= '0;
    end else begin
      // Stage 2 only moves when empty or draining, so a stalled word holds.
      if (w_s1_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_instr <= w_word;
          r_err   <= w_err;
        end
      end
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_fmt      <= bus.fmt;
        r_rd       <= bus.rd;
        r_rs1      <= bus.rs1;
        r_rs2      <= bus.rs2;
        r_f3       <= bus.funct3;
        r_f7       <= bus.funct7;
        r_imm      <= bus.imm;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
      if (r_s2_valid && bus.out_ready) r_count <= r_count + 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.instr     = r_instr;
  assign bus.err       = r_err;
  assign bus.count     = r_count;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded vectors, latency, backpressure
// ordering and mid-flight reset, checked through a {err,instr} scoreboard.
module tb_instr_encoder;
  localparam int CNT_W = 16;
  localparam int W     = 33;
`ifdef IMM_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   n_hs;
  logic [W-1:0] exp_q[$];

  instr_encoder_if #(.CNT_W(CNT_W)) ifc ();

  instr_encoder #(.CNT_W(CNT_W), .NOP_WORD(32'h0000_0013)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: handshakes are decided by values settled after the negedge.
  always begin
    @(negedge clk);
    #2;
    if (!reset && ifc.out_valid && ifc.out_ready) begin
      n_hs++;
      if (exp_q.size() == 0) begin
        check("unexpected_word", ifc.instr, 32'hxxxx_xxxx);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("instr", ifc.instr, e[31:0]);
        check("err", {31'd0, ifc.err}, {31'd0, e[32]});
      end
    end
  end

  // Driver tasks: called at a negedge, return at a negedge.
  task automatic set_fields(input logic [3:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] imm);
    ifc.fmt = fmt; ifc.rd = rd; ifc.rs1 = rs1; ifc.rs2 = rs2;
    ifc.funct3 = f3; ifc.funct7 = f7; ifc.imm = imm;
  endtask

  task automatic send(input logic [3:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, input logic [31:0] exp_instr, input logic exp_err);
    logic ok;
    ok = 1'b0;
    set_fields(fmt, rd, rs1, rs2, f3, f7, imm);
    exp_q.push_back({exp_err, exp_instr});
    ifc.in_valid = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      #1;
      ok = ifc.in_ready;
      @(posedge clk);
      @(negedge clk);
    end
    ifc.in_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    check("drain_left", exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    n_hs = 0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; n_hs = 0;
    reset = 1'b1;
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
    set_fields(4'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
    check("rst_instr", ifc.instr, 32'd0);
    check("rst_err", {31'd0, ifc.err}, 32'd0);
    check("rst_count", {16'd0, ifc.count}, 32'd0);
    check("rst_in_ready", {31'd0, ifc.in_ready}, 32'd1);

    // Latency: accepted at edge N, visible after edge N+2.
    @(negedge clk);
    set_fields(4'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    exp_q.push_back({1'b0, 32'hFFF0_0293});
    ifc.in_valid = 1'b1;
    #1;
    check("lat_in_ready", {31'd0, ifc.in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    check("lat_n1", {31'd0, ifc.out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("lat_n2", {31'd0, ifc.out_valid}, 32'd1);
    wait_drain();

    // Directed encoding vectors, back to back.
    send(4'd4, 5'd0,  5'd1, 5'd2, 3'd0, 7'd0,    32'd8,          32'h0020_8463, 1'b0);
    send(4'd7, 5'd1,  5'd0, 5'd0, 3'd0, 7'd0,    32'h0000_0800,  32'h0010_00EF, 1'b0);
    send(4'd5, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0,    32'h1234_5000,  32'h1234_5537, 1'b0);
    send(4'd0, 5'd3,  5'd1, 5'd2, 3'd0, 7'h20,   32'd0,          32'h4020_81B3, 1'b0);
    send(4'd3, 5'd0,  5'd1, 5'd2, 3'd2, 7'd0,    32'd8,          32'h0020_A423, 1'b0);
    send(4'd1, 5'd5,  5'd6, 5'd0, 3'd5, 7'h20,   32'd3,          32'h4033_5293, 1'b0);
    send(4'd2, 5'd5,  5'd2, 5'd0, 3'd2, 7'd0,    32'hFFFF_FFFC,  32'hFFC1_2283, 1'b0);
    send(4'd8, 5'd0,  5'd1, 5'd0, 3'd0, 7'd0,    32'd0,          32'h0000_8067, 1'b0);
    send(4'd6, 5'd1,  5'd0, 5'd0, 3'd0, 7'd0,    32'hFFFF_F000,  32'hFFFF_F097, 1'b0);
    send(4'd12, 5'd7, 5'd3, 5'd4, 3'd1, 7'h7F,   32'h1234_5678,  32'h0000_0013, 1'b1);
    send(4'd3, 5'd0,  5'd0, 5'd0, 3'd0, 7'd0,    32'd2048,       32'h8000_0023, RC);
    send(4'd4, 5'd0,  5'd1, 5'd2, 3'd0, 7'd0,    32'd9,          32'h0020_8463, RC);
    send(4'd5, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0,    32'h1234_5FFF,  32'h1234_5537, RC);
    wait_drain();
    check("count_total", {16'd0, ifc.count}, n_hs);

    // Backpressure: two entries fill the pipe, the third waits.
    do_reset();
    ifc.out_ready = 1'b0;
    send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0093, 1'b0);
    send(4'd1, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h0020_0113, 1'b0);
    set_fields(4'd1, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    ifc.in_valid = 1'b1;
    repeat (3) begin
      #1;
      check("bp_in_ready", {31'd0, ifc.in_ready}, 32'd0);
      check("bp_hold_instr", ifc.instr, 32'h0010_0093);
      @(posedge clk);
      @(negedge clk);
    end
    ifc.out_ready = 1'b1;
    send(4'd1, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0030_0193, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #3;
    check("bp_count", {16'd0, ifc.count}, 32'd3);
    check("bp_empty", {31'd0, ifc.out_valid}, 32'd0);
    check("bp_q_empty", exp_q.size(), 32'd0);

    // Reset with both stages full drops everything.
    ifc.out_ready = 1'b0;
    send(4'd0, 5'd4, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 32'h0010_8233, 1'b0);
    send(4'd0, 5'd5, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 32'h0010_82B3, 1'b0);
    do_reset();
    #1;
    check("mr_out_valid", {31'd0, ifc.out_valid}, 32'd0);
    check("mr_count", {16'd0, ifc.count}, 32'd0);
    check("mr_in_ready", {31'd0, ifc.in_ready}, 32'd1);
    ifc.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("mr_no_stale", n_hs, 32'd0);
    check("mr_count_after", {16'd0, ifc.count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
